avalon_ram_param: RTL and testbench
===================================

AVALON_RAM_PARAM -- requirements
Module: avalon_ram_param

Interface
REQ-001 Parameter ADDR_WIDTH, default 10; word-address bits, so depth is 2**ADDR_WIDTH 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 1; fixed wait states per transfer, legal range 0..15.
REQ-003 Parameter BASE_ADDR, default 32'h00000000; byte address of word 0.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 address  input  32  Avalon byte address from master.
REQ-007 read  input  1  Avalon read request.
REQ-008 write  input  1  Avalon write request.
REQ-009 writedata  input  32  write data.
REQ-010 byteenable  input  4  byte lane enables; bit n covers writedata[8n+7:8n].
REQ-011 waitrequest  output  1  high stalls master; low marks transfer completion.
REQ-012 readdata  output  32  registered read data, valid in the completion cycle.
REQ-013 err  output  1  high in the completion cycle of an illegal transfer.
REQ-014 load_en  input  1  preload strobe, independent of the Avalon port.
REQ-015 load_addr  input  ADDR_WIDTH  preload word index.
REQ-016 load_data  input  32  preload word, full-word write.

Function
REQ-017 FSM states IDLE, BUSY, DONE; waitrequest = (read|write) when not in DONE, 0 in DONE.
REQ-018 IDLE: read|write high -> latch address, writedata, byteenable, op; cnt<=WAIT_CYCLES; to BUSY, or directly to DONE when WAIT_CYCLES=0.
REQ-019 BUSY: cnt decrements each cycle; at cnt==1 (or entry with cnt 0) next state DONE, readdata loaded on that edge.
REQ-020 Total transfer: WAIT_CYCLES+2 cycles from request to completion edge, waitrequest low exactly one cycle.
REQ-021 DONE: writes committed at the DONE edge, only bytes with byteenable set; always return to IDLE next.
REQ-022 Word index = (address-BASE_ADDR)>>2; illegal if address[1:0]!=0 or index >= 2**ADDR_WIDTH.
REQ-023 Illegal transfer: full latency still applies; err=1 and readdata=0 in DONE; memory unchanged.
REQ-024 read and write both high on acceptance: treated as write; err=1 in DONE.
REQ-025 Master deasserting read and write while in BUSY: abort to IDLE next edge, no write, err stays 0.
REQ-026 load_en high writes load_data to load_addr on that edge in any state.
REQ-027 load_en and DONE write to the same word on the same edge: bus write bytes win, preload supplies unenabled bytes.
REQ-028 readdata holds its value outside DONE; err is 0 outside DONE.

Reset
REQ-029 reset: state<=IDLE, cnt<=0, readdata<=0, err<=0; in-flight transfer aborted without write.
REQ-030 Memory contents are not cleared by reset; load_en is honoured during reset.

Configuration
REQ-031 Macro AVALON_RAM_WAIT_JITTER_EN defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) advances once per accepted transfer; wait count = WAIT_CYCLES + lfsr[1:0].
REQ-032 Macro undefined: no LFSR, wait count is exactly WAIT_CYCLES.

Verification
REQ-033 Preload word 1 = 32'h24020010 at load_addr 1, read address 32'h4, WAIT_CYCLES=1 -> waitrequest high 2 cycles, then low with readdata 32'h24020010, err 0.
REQ-034 Word 2 = 32'h11223344, write 32'hAABBCCDD byteenable 4'b0101 to 32'h8, read back -> 32'h11BB33DD.
REQ-035 Read address 32'h6, then address 4*2**ADDR_WIDTH -> each completes with err 1, readdata 0.
REQ-036 Write to 32'hC, drop write in BUSY (WAIT_CYCLES=3) -> read 32'hC returns prior value, err 0; repeat with reset mid-BUSY -> same.
REQ-037 WAIT_CYCLES=0 read -> waitrequest low on second cycle of request; with AVALON_RAM_WAIT_JITTER_EN, first transfer after reset takes WAIT_CYCLES+1+2 cycles (lfsr[1:0]=2'b01).

Source files
------------

// File: rtl/avalon_ram_param_if.sv
// Avalon-MM slave bus bundle for the parameterised word RAM.
interface avalon_ram_param_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        err;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, err
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, err
    );
endinterface

// File: rtl/avalon_ram_param.sv
// Avalon-MM word RAM with fixed wait states, byte enables and a side preload port.
// Optional AVALON_RAM_WAIT_JITTER_EN adds 0..3 LFSR-driven extra wait states per transfer.
//
// state | meaning
// IDLE  | no transfer; accepts read/write and latches the request
// BUSY  | counting wait states; drops back to IDLE if the master withdraws
// DONE  | completion cycle: waitrequest low, readdata/err valid, write commits at exit
module avalon_ram_param #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    avalon_ram_param_if.slave     bus,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]           load_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e                state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic                  is_write_q, is_write_d;
    logic                  bad_q, bad_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [31:0]           mem [DEPTH];

    logic                  req;
    logic [31:0]           offset;
    logic [31:0]           word_off;
    logic                  addr_bad;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic [4:0]            wait_cnt;
    logic                  enter_done;
    logic                  done_bad;
    logic                  done_write;
    logic [ADDR_WIDTH-1:0] done_idx;
    logic                  commit;

    assign req      = bus.read | bus.write;
    assign offset   = bus.address - BASE_ADDR;
    assign word_off = offset >> 2;
    assign addr_bad = (bus.address[1:0] != 2'b00) || ((word_off >> ADDR_WIDTH) != 32'd0);
    assign cur_idx  = word_off[ADDR_WIDTH-1:0];

`ifdef AVALON_RAM_WAIT_JITTER_EN
    logic [7:0] lfsr_q, lfsr_d;
    assign wait_cnt = 5'(WAIT_CYCLES) + {3'b000, lfsr_q[1:0]};
`else
    assign wait_cnt = 5'(WAIT_CYCLES);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        is_write_d = is_write_q;
        bad_d      = bad_q;
        rdata_d    = rdata_q;
        err_d      = 1'b0;
        enter_done = 1'b0;
        done_bad   = bad_q;
        done_write = is_write_q;
        done_idx   = idx_q;
`ifdef AVALON_RAM_WAIT_JITTER_EN
        lfsr_d     = lfsr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d      = cur_idx;
                    wdata_d    = bus.writedata;
                    be_d       = bus.byteenable;
                    is_write_d = bus.write;
                    // read and write together are executed as a faulted write
                    bad_d      = addr_bad | (bus.read & bus.write);
                    cnt_d      = wait_cnt;
`ifdef AVALON_RAM_WAIT_JITTER_EN
                    lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
                    if (wait_cnt == 5'd0) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                        done_bad   = bad_d;
                        done_write = bus.write;
                        done_idx   = cur_idx;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = (cnt_q != 5'd0) ? cnt_q - 5'd1 : 5'd0;
                    if (cnt_q <= 5'd1) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_done) begin
            err_d = done_bad;
            if (done_bad) begin
                rdata_d = 32'd0;
            end else if (!done_write) begin
                rdata_d = mem[done_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            is_write_q <= 1'b0;
            bad_q      <= 1'b0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
`ifdef AVALON_RAM_WAIT_JITTER_EN
            lfsr_q     <= 8'hA5;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            is_write_q <= is_write_d;
            bad_q      <= bad_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
`ifdef AVALON_RAM_WAIT_JITTER_EN
            lfsr_q     <= lfsr_d;
`endif
        end
    end

    assign commit = (state_q == DONE) && is_write_q && !bad_q && !reset;

    // Bus bytes are assigned after the preload so they win on a same-word collision.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign bus.waitrequest = req && (state_q != DONE);
    assign bus.readdata    = rdata_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_avalon_ram_param.sv
// Bench for avalon_ram_param: three instances (1, 3 and 0 wait states) driven from shared tasks.
module tb_avalon_ram_param;

    logic clk;
    logic reset;

    logic [31:0] t_addr  [3];
    logic        t_rd    [3];
    logic        t_wr    [3];
    logic [31:0] t_wdata [3];
    logic [3:0]  t_be    [3];
    logic        t_wait  [3];
    logic [31:0] t_rdata [3];
    logic        t_err   [3];
    logic        t_load_en   [3];
    logic [9:0]  t_load_addr [3];
    logic [31:0] t_load_data [3];
    logic [7:0]  lfsr_m  [3];

    int total;
    int bad;

    avalon_ram_param_if if0 ();
    avalon_ram_param_if if1 ();
    avalon_ram_param_if if2 ();

    assign if0.address = t_addr[0];  assign if0.read = t_rd[0];  assign if0.write = t_wr[0];
    assign if0.writedata = t_wdata[0]; assign if0.byteenable = t_be[0];
    assign t_wait[0] = if0.waitrequest; assign t_rdata[0] = if0.readdata; assign t_err[0] = if0.err;

    assign if1.address = t_addr[1];  assign if1.read = t_rd[1];  assign if1.write = t_wr[1];
    assign if1.writedata = t_wdata[1]; assign if1.byteenable = t_be[1];
    assign t_wait[1] = if1.waitrequest; assign t_rdata[1] = if1.readdata; assign t_err[1] = if1.err;

    assign if2.address = t_addr[2];  assign if2.read = t_rd[2];  assign if2.write = t_wr[2];
    assign if2.writedata = t_wdata[2]; assign if2.byteenable = t_be[2];
    assign t_wait[2] = if2.waitrequest; assign t_rdata[2] = if2.readdata; assign t_err[2] = if2.err;

    avalon_ram_param #(.ADDR_WIDTH(10), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) u_dut_w1 (
        .clk(clk), .reset(reset), .bus(if0),
        .load_en(t_load_en[0]), .load_addr(t_load_addr[0]), .load_data(t_load_data[0])
    );
    avalon_ram_param #(.ADDR_WIDTH(10), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u_dut_w3 (
        .clk(clk), .reset(reset), .bus(if1),
        .load_en(t_load_en[1]), .load_addr(t_load_addr[1]), .load_data(t_load_data[1])
    );
    avalon_ram_param #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut_w0 (
        .clk(clk), .reset(reset), .bus(if2),
        .load_en(t_load_en[2]), .load_addr(t_load_addr[2]), .load_data(t_load_data[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          chk_rd;
        int          lat;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] er;
        logic        ee;
        bit          chk;
        string       nm;
    } vec_t;

    exp_t sb[$];
    vec_t vt[13];

    function automatic int wc(input int d);
        case (d)
            0: return 1;
            1: return 3;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Extra wait states contributed by the jitter LFSR, advanced once per accepted transfer.
    task automatic next_jit(input int d, output int j);
`ifdef AVALON_RAM_WAIT_JITTER_EN
        j = int'(lfsr_m[d][1:0]);
        lfsr_m[d] = {lfsr_m[d][6:0], lfsr_m[d][7] ^ lfsr_m[d][5] ^ lfsr_m[d][4] ^ lfsr_m[d][3]};
`else
        j = 0;
`endif
    endtask

    task automatic reset_models();
        for (int i = 0; i < 3; i++) lfsr_m[i] = 8'hA5;
    endtask

    task automatic preload(input int d, input logic [9:0] a, input logic [31:0] v);
        @(negedge clk);
        t_load_en[d] = 1'b1; t_load_addr[d] = a; t_load_data[d] = v;
        @(negedge clk);
        t_load_en[d] = 1'b0;
    endtask

    task automatic xfer(input int d, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] er, input logic ee, input bit chk_rd,
                        input bit coll, input logic [31:0] cdata, input string nm);
        exp_t e;
        exp_t got;
        int   n;
        int   j;
        bit   done;
        next_jit(d, j);
        e.rdata = er; e.err = ee; e.chk_rd = chk_rd; e.lat = wc(d) + 2 + j;
        sb.push_back(e);
        @(negedge clk);
        t_rd[d] = rd; t_wr[d] = wr; t_addr[d] = a; t_wdata[d] = wd; t_be[d] = be;
        n = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            #1;
            n++;
            if (!t_wait[d]) begin
                done = 1'b1;
                got = sb.pop_front();
                chk({nm, "_lat"}, 32'(n), 32'(got.lat));
                chk({nm, "_err"}, {31'd0, t_err[d]}, {31'd0, got.err});
                if (got.chk_rd) chk({nm, "_rdata"}, t_rdata[d], got.rdata);
                if (coll) begin
                    t_load_en[d] = 1'b1; t_load_addr[d] = a[11:2]; t_load_data[d] = cdata;
                end
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL %s_timeout: no completion after %0d cycles, want %0d", nm, n, e.lat);
            void'(sb.pop_front());
        end
        @(negedge clk);
        t_rd[d] = 1'b0; t_wr[d] = 1'b0; t_load_en[d] = 1'b0;
        #1;
        chk({nm, "_err_after"}, {31'd0, t_err[d]}, 32'd0);
    endtask

    initial begin
        int j;
        total = 0;
        bad = 0;
        reset = 1'b1;
        reset_models();
        for (int i = 0; i < 3; i++) begin
            t_addr[i] = 32'd0; t_rd[i] = 1'b0; t_wr[i] = 1'b0; t_wdata[i] = 32'd0; t_be[i] = 4'd0;
            t_load_en[i] = 1'b0; t_load_addr[i] = 10'd0; t_load_data[i] = 32'd0;
        end

        vt[0]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         4'h0,    32'h2402_0010, 1'b0, 1'b1, "rd_w1"};
        vt[1]  = '{1'b0, 1'b1, 32'h0000_0008, 32'hAABB_CCDD, 4'b0101, 32'h0,         1'b0, 1'b0, "wr_be0101"};
        vt[2]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         4'h0,    32'h11BB_33DD, 1'b0, 1'b1, "rd_merge"};
        vt[3]  = '{1'b1, 1'b0, 32'h0000_0006, 32'h0,         4'h0,    32'h0,         1'b1, 1'b1, "rd_misalign"};
        vt[4]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         4'h0,    32'h0,         1'b1, 1'b1, "rd_range"};
        vt[5]  = '{1'b0, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF,    32'h0,         1'b1, 1'b0, "wr_range"};
        vt[6]  = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,         4'h0,    32'hCAFE_F00D, 1'b0, 1'b1, "rd_w3"};
        vt[7]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h0,         4'hF,    32'h0,         1'b1, 1'b0, "rd_and_wr"};
        vt[8]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF,    32'h0,         1'b0, 1'b0, "wr_full"};
        vt[9]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0,    32'h1234_5678, 1'b0, 1'b1, "rd_full"};
        vt[10] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         4'b1000, 32'h0,         1'b0, 1'b0, "wr_top_byte"};
        vt[11] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0,    32'h0034_5678, 1'b0, 1'b1, "rd_top_byte"};
        vt[12] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         4'h0,    32'h5A5A_5A5A, 1'b0, 1'b1, "rd_last"};

        // preload issued while reset is held
        preload(0, 10'd1, 32'h2402_0010);
        preload(2, 10'd1, 32'h2402_0010);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_rdata", t_rdata[0], 32'd0);
        chk("rst_err", {31'd0, t_err[0]}, 32'd0);
        chk("rst_wait", {31'd0, t_wait[0]}, 32'd0);

        preload(0, 10'd2, 32'h1122_3344);
        preload(0, 10'd3, 32'hCAFE_F00D);
        preload(0, 10'd1023, 32'h5A5A_5A5A);
        preload(1, 10'd3, 32'h0C0C_0C0C);

        for (int i = 0; i < 13; i++) begin
            xfer(0, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].be,
                 vt[i].er, vt[i].ee, vt[i].chk, 1'b0, 32'h0, vt[i].nm);
        end

        // bus write and preload hitting the same word on the commit edge
        xfer(0, 1'b0, 1'b1, 32'h14, 32'hAABB_CCDD, 4'b0011, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1122_3344, "coll_wr");
        xfer(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 32'h1122_CCDD, 1'b0, 1'b1, 1'b0, 32'h0, "coll_rd");

        // zero wait states
        xfer(2, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 32'h2402_0010, 1'b0, 1'b1, 1'b0, 32'h0, "rd_w0");

        // master withdraws mid-BUSY
        next_jit(1, j);
        @(negedge clk);
        t_wr[1] = 1'b1; t_addr[1] = 32'hC; t_wdata[1] = 32'hFFFF_FFFF; t_be[1] = 4'hF;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("abort_wait_hi", {31'd0, t_wait[1]}, 32'd1);
        t_wr[1] = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_err", {31'd0, t_err[1]}, 32'd0);
        chk("abort_wait_lo", {31'd0, t_wait[1]}, 32'd0);
        xfer(1, 1'b1, 1'b0, 32'hC, 32'h0, 4'h0, 32'h0C0C_0C0C, 1'b0, 1'b1, 1'b0, 32'h0, "abort_rd");

        // reset mid-BUSY
        next_jit(1, j);
        @(negedge clk);
        t_wr[1] = 1'b1; t_addr[1] = 32'hC; t_wdata[1] = 32'hFFFF_FFFF; t_be[1] = 4'hF;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        t_wr[1] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        reset_models();
        #1;
        chk("rstmid_rdata", t_rdata[1], 32'd0);
        chk("rstmid_err", {31'd0, t_err[1]}, 32'd0);
        xfer(1, 1'b1, 1'b0, 32'hC, 32'h0, 4'h0, 32'h0C0C_0C0C, 1'b0, 1'b1, 1'b0, 32'h0, "rstmid_rd");
        xfer(0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 32'h2402_0010, 1'b0, 1'b1, 1'b0, 32'h0, "mem_kept");
        xfer(2, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 32'h2402_0010, 1'b0, 1'b1, 1'b0, 32'h0, "rd_w0_again");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
